// File: rtl/mac_pkg.sv
// Shared constants, state encoding and slot-offset helper for the MAC operand loader.
package mac_pkg;

    localparam int N_W = 16;
    localparam int DW  = 10;
    localparam int CW  = 5;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic int slot_lo(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/mac_frame_ctrl.sv
// Frame sequencer: beat counter, LOAD/HOLD/DROP state machine, framing-error detection.
// Outputs are registered; s_ready drops for the whole HOLD phase until m_ready completes the handshake.
module mac_frame_ctrl
    import mac_pkg::*;
#(
    parameter int N_W = mac_pkg::N_W,
    parameter int CW  = mac_pkg::CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          s_valid,
    input  logic          s_last,
    input  logic          m_ready,
    output logic          s_ready,
    output logic          m_valid,
    output logic          frame_err,
    output logic          wr_en,
    output logic          cap_en,
    output logic [CW-1:0] wr_idx
);

    localparam logic [CW-1:0] BIAS_BEAT = CW'(N_W);

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          err_nxt;
    logic          accept;

    assign accept = s_valid & s_ready;
    assign wr_idx = count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= LOAD;
            count     <= '0;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            s_ready   <= (state_nxt != HOLD);
            m_valid   <= (state_nxt == HOLD);
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        err_nxt   = 1'b0;
        wr_en     = 1'b0;
        cap_en    = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (count < BIAS_BEAT) begin
                        if (!s_last) begin
                            wr_en     = 1'b1;
                            count_nxt = count + 1'b1;
                        end else begin
                            // early last: restart, leave stale slots in place
                            err_nxt   = 1'b1;
                            count_nxt = '0;
                        end
                    end else begin
                        count_nxt = '0;
                        if (s_last) begin
                            cap_en    = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = DROP;
                        end
                    end
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                end
            end
            HOLD: begin
                if (m_valid && m_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
                count_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/mac_frame_loader.sv
// Serial-to-parallel MAC operand loader; packed frame valid one cycle after the bias beat.
// Serial input is stalled (s_ready=0) while a packed frame waits for m_ready.
module mac_frame_loader
    import mac_pkg::*;
#(
    parameter int N_W = mac_pkg::N_W,
    parameter int DW  = mac_pkg::DW,
    parameter int CW  = mac_pkg::CW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    input  logic              s_last,
    input  logic [N_W-1:0]    s_x,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_W*DW-1:0] m_ws,
    output logic [DW-1:0]     m_bias,
    output logic [N_W-1:0]    m_in,
    output logic              frame_err
);

    logic          wr_en;
    logic          cap_en;
    logic [CW-1:0] wr_idx;

    mac_frame_ctrl #(
        .N_W (N_W),
        .CW  (CW)
    ) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .m_ready   (m_ready),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .frame_err (frame_err),
        .wr_en     (wr_en),
        .cap_en    (cap_en),
        .wr_idx    (wr_idx)
    );

    // Slots are overwritten in place; m_ws is only meaningful while m_valid is high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_ws   <= '0;
            m_bias <= '0;
            m_in   <= '0;
        end else begin
            if (wr_en) begin
                m_ws[slot_lo(int'(wr_idx), DW) +: DW] <= s_data;
            end
            if (cap_en) begin
                m_bias <= s_data;
                m_in   <= s_x;
            end
        end
    end

endmodule

// File: tb/tb_mac_frame_loader.sv
// Scoreboard bench for mac_frame_loader: expected frames queued on send, compared at the output handshake.
module tb_mac_frame_loader;

    typedef struct packed {
        logic [159:0] ws;
        logic [9:0]   bias;
        logic [15:0]  x;
    } frm_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [9:0]   s_data = '0;
    logic         s_last = 1'b0;
    logic [15:0]  s_x = '0;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [159:0] m_ws;
    logic [9:0]   m_bias;
    logic [15:0]  m_in;
    logic         frame_err;

    int   total = 0;
    int   bad = 0;
    int   err_seen = 0;
    int   err_exp = 0;
    frm_t sb[$];
    frm_t f1, fr, fe;

    mac_frame_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_x       (s_x),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_ws      (m_ws),
        .m_bias    (m_bias),
        .m_in      (m_in),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor: every handshake must match the oldest expected frame.
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_err) err_seen++;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    fe = sb.pop_front();
                    chk("m_ws", m_ws, fe.ws);
                    chk("m_bias", {150'd0, m_bias}, {150'd0, fe.bias});
                    chk("m_in", {144'd0, m_in}, {144'd0, fe.x});
                end
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send_beat(input logic [9:0] d, input logic last, input logic [15:0] x, input bit gap);
        int n;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_x     = x;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) chk("s_ready_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input frm_t f, input bit gap, input bit push);
        if (push) sb.push_back(f);
        for (int k = 0; k < 16; k++) send_beat(f.ws[k*10 +: 10], 1'b0, 16'($urandom), gap);
        send_beat(f.bias, 1'b1, f.x, gap);
    endtask

    function automatic frm_t rand_frame();
        frm_t f;
        for (int k = 0; k < 16; k++) f.ws[k*10 +: 10] = 10'($urandom);
        f.bias = 10'($urandom);
        f.x    = 16'($urandom);
        return f;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", {159'd0, m_valid}, 0);
        chk("rst_s_ready", {159'd0, s_ready}, 1);
        chk("rst_m_ws", m_ws, 0);
        chk("rst_m_bias", {150'd0, m_bias}, 0);
        chk("rst_m_in", {144'd0, m_in}, 0);
        chk("rst_frame_err", {159'd0, frame_err}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        f1.ws = '0;
        f1.ws[9:0]     = 10'd100;
        f1.ws[19:10]   = 10'd200;
        f1.ws[149:140] = 10'h20C;
        f1.ws[159:150] = 10'h0FF;
        f1.bias = 10'd5;
        f1.x    = 16'hFFFF;

        // Reset state
        idle(2);
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_s_ready", {159'd0, s_ready}, 1);
        chk("init_m_valid", {159'd0, m_valid}, 0);
        chk("init_m_ws", m_ws, 0);
        chk("init_frame_err", {159'd0, frame_err}, 0);
        @(posedge clk); #1;

        // Nominal frame, latency and re-open of s_ready
        send_frame(f1, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_m_valid", {159'd0, m_valid}, 1);
        chk("lat_s_ready", {159'd0, s_ready}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_hs_s_ready", {159'd0, s_ready}, 1);
        chk("post_hs_m_valid", {159'd0, m_valid}, 0);
        @(posedge clk); #1;

        // Backpressure
        m_ready = 1'b0;
        send_frame(f1, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_m_valid", {159'd0, m_valid}, 1);
            chk("bp_s_ready", {159'd0, s_ready}, 0);
            chk("bp_m_ws", m_ws, f1.ws);
            chk("bp_m_bias", {150'd0, m_bias}, {150'd0, f1.bias});
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_s_ready", {159'd0, s_ready}, 1);
        chk("bp_release_m_valid", {159'd0, m_valid}, 0);
        @(posedge clk); #1;

        // Early last on beat 5
        for (int k = 0; k < 5; k++) send_beat(10'($urandom), 1'b0, 16'h0, 1'b0);
        send_beat(10'h3AA, 1'b1, 16'h1234, 1'b0);
        err_exp++;
        idle(3);
        chk("early_err_count", 160'(err_seen), 160'(err_exp));
        fr = rand_frame();
        send_frame(fr, 1'b0, 1'b1);
        idle(3);

        // Missing last: beat 16 without s_last, junk, then a closing last
        for (int k = 0; k < 17; k++) send_beat(10'($urandom), 1'b0, 16'h0, 1'b0);
        err_exp++;
        for (int k = 0; k < 3; k++) send_beat(10'($urandom), 1'b0, 16'h0, 1'b0);
        send_beat(10'h155, 1'b1, 16'hBEEF, 1'b0);
        idle(3);
        chk("missing_err_count", 160'(err_seen), 160'(err_exp));
        fr = rand_frame();
        send_frame(fr, 1'b0, 1'b1);
        idle(3);

        // Reset at beat 8, then a clean frame
        for (int k = 0; k < 8; k++) send_beat(10'($urandom), 1'b0, 16'h0, 1'b0);
        pulse_reset();
        fr = rand_frame();
        send_frame(fr, 1'b0, 1'b1);
        idle(3);

        // Reset while holding an unconsumed frame
        m_ready = 1'b0;
        send_frame(rand_frame(), 1'b0, 1'b0);
        idle(2);
        pulse_reset();
        m_ready = 1'b1;
        idle(2);
        fr = rand_frame();
        send_frame(fr, 1'b0, 1'b1);
        idle(3);

        // Gapped input, same content as the nominal frame
        send_frame(f1, 1'b1, 1'b1);
        idle(5);

        chk("sb_drained", 160'(sb.size()), 0);
        chk("final_err_count", 160'(err_seen), 160'(err_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
